// File: rtl/mux_scan_pkg.sv
// Shared types and elaboration helpers for the mux scan sequencer.
// Optional parity output is controlled by the MUX_SCAN_PARITY_EN macro (see mux_scan_sequencer).
package mux_scan_pkg;

    localparam int N_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } scan_state_t;

    function automatic bit n_is_legal(input int n);
        return n >= 2;
    endfunction

    // Clamped so an illegal N still elaborates far enough to hit the check in the top.
    function automatic int sel_width(input int n);
        return n_is_legal(n) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_counter.sv
// Select counter: walks 0..N-1, wraps to 0 after the terminal count.
module mux_scan_counter
    import mux_scan_pkg::*;
#(
    parameter  int N    = N_DEFAULT,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [SELW-1:0] cnt,
    output logic            tc
);

    logic [SELW-1:0] cnt_q;
    logic [SELW-1:0] cnt_d;

    assign tc  = (cnt_q == SELW'(N - 1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Sweeps an N-to-1 mux select, captures one bit per select into a word, offers it on valid/ready.
// Define MUX_SCAN_PARITY_EN to add the registered out_parity output (^out_data).
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter  int N    = N_DEFAULT,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [SELW-1:0] sel,
    input  logic            y_in,
    output logic            busy,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
`ifdef MUX_SCAN_PARITY_EN
    output logic            out_parity,
`endif
    input  logic            out_ready
);

    if (!n_is_legal(N)) begin : g_n_check
        $error("mux_scan_sequencer: N must be >= 2");
    end

    scan_state_t state_q, state_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic         cnt_clr, cnt_en, cnt_tc;

    mux_scan_counter #(.N(N)) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (sel),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        cnt_clr    = (state_q != SCAN);
        cnt_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = SCAN;
            end
            SCAN: begin
                cnt_en          = 1'b1;
                out_data_d[sel] = y_in;
                if (cnt_tc) state_d = HOLD;
            end
            HOLD: begin
                // start is only honoured together with the handshake, giving back-to-back scans.
                if (out_ready) state_d = start ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic out_parity_q, out_parity_d;

    always_comb begin
        out_parity_d = out_parity_q;
        if (state_q == SCAN && cnt_tc) out_parity_d = ^out_data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= out_parity_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer (N=6) with a position-based reference model.
module tb_mux_scan_sequencer;

    localparam int N    = 6;
    localparam int SELW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [SELW-1:0] sel;
    logic            y_in;
    logic            busy;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_parity;
    logic [N-1:0]    mux_in;

    always #5 clk = ~clk;

    // Behavioural stand-in for the mux the sequencer drives.
    assign y_in = (int'(sel) < N) ? mux_in[sel] : 1'bx;

    mux_scan_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel       (sel),
        .y_in      (y_in),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef MUX_SCAN_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );
`ifndef MUX_SCAN_PARITY_EN
    assign out_parity = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_pos = -1 idle, 0..N-1 scanning bit m_pos, N holding a finished word.
    int           m_pos;
    logic [N-1:0] m_word;
    logic         m_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_pos = -1; m_word = '0; m_par = 1'b0;
        end else if (m_pos < 0) begin
            if (start) m_pos = 0;
        end else if (m_pos < N) begin
            m_word[m_pos] = mux_in[m_pos];
            m_pos++;
            if (m_pos == N) m_par = ^m_word;
        end else if (out_ready) begin
            m_pos = start ? 0 : -1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sel"},   32'(sel),       (m_pos >= 0 && m_pos < N) ? 32'(m_pos) : 32'd0);
        chk({tag, ".busy"},  32'(busy),      32'(m_pos >= 0));
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_pos == N));
        chk({tag, ".data"},  32'(out_data),  32'(m_word));
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, ".parity"}, 32'(out_parity), 32'(m_par));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Pulses start for one cycle and counts edges (from the driving edge) until out_valid.
    task automatic scan_word(input logic [N-1:0] pattern, output int lat);
        mux_in = pattern;
        start  = 1'b1;
        lat    = 0;
        do begin
            tick("scan");
            start = 1'b0;
            lat++;
        end while (!out_valid && lat < 30);
        if (!out_valid) chk("scan.timeout", 32'(out_valid), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] inputs;
        logic [N-1:0] exp_word;
        logic         exp_par;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        int n;
        logic [N-1:0] held;

        vecs[0] = '{6'b101101, 6'b101101, 1'b0};
        vecs[1] = '{6'b000111, 6'b000111, 1'b1};
        vecs[2] = '{6'b010011, 6'b010011, 1'b1};
        vecs[3] = '{6'b111111, 6'b111111, 1'b0};
        vecs[4] = '{6'b100000, 6'b100000, 1'b1};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; mux_in = '0;
        m_pos = -1; m_word = '0; m_par = 1'b0;
        tick("reset");
        tick("reset");
        chk("reset.sel", 32'(sel), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick("idle");

        // Table: single words, latency and content, then release.
        for (int i = 0; i < 5; i++) begin
            scan_word(vecs[i].inputs, lat);
            chk("tbl.latency", 32'(lat), 32'd7);
            chk("tbl.word", 32'(out_data), 32'(vecs[i].exp_word));
`ifdef MUX_SCAN_PARITY_EN
            chk("tbl.parity", 32'(out_parity), 32'(vecs[i].exp_par));
`endif
            out_ready = 1'b1;
            tick("tbl.accept");
            out_ready = 1'b0;
            chk("tbl.idle", 32'(busy), 32'd0);
        end

        // Select walks 0..N-1 on consecutive cycles.
        mux_in = 6'b101101;
        start  = 1'b1;
        tick("walk");
        start  = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("walk.sel", 32'(sel), 32'(i));
            tick("walk");
        end
        chk("walk.valid", 32'(out_valid), 32'd1);

        // Backpressure: word frozen while out_ready is low, idle one cycle after release.
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            tick("bp");
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.data", 32'(out_data), 32'(6'b101101));
        end
        chk("bp.held", 32'(out_data), 32'(held));
        out_ready = 1'b1;
        tick("bp.release");
        out_ready = 1'b0;
        chk("bp.idle", 32'(busy), 32'd0);
        chk("bp.novalid", 32'(out_valid), 32'd0);

        // start mid-scan is ignored: exactly one word, no second scan.
        mux_in = 6'b110010;
        start  = 1'b1;
        tick("ign");
        start  = 1'b0;
        n = 0;
        while (sel != 2 && n < 20) begin tick("ign"); n++; end
        chk("ign.reach", 32'(sel), 32'd2);
        start = 1'b1;
        tick("ign");
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick("ign"); n++; end
        chk("ign.word", 32'(out_data), 32'(6'b110010));
        out_ready = 1'b1;
        tick("ign");
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick("ign.quiet");
        chk("ign.nosecond", 32'(busy), 32'd0);

        // Reset at sel==3 drops the partial word with no valid pulse afterwards.
        mux_in = 6'b011011;
        start  = 1'b1;
        tick("rst");
        start  = 1'b0;
        n = 0;
        while (sel != 3 && n < 20) begin tick("rst"); n++; end
        chk("rst.reach", 32'(sel), 32'd3);
        rst = 1'b1;
        tick("rst");
        rst = 1'b0;
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.data", 32'(out_data), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick("rst.after");
            chk("rst.novalid", 32'(out_valid), 32'd0);
        end

        // Back-to-back: handshake with start goes straight into the next scan.
        scan_word(6'b101101, lat);
        chk("b2b.first", 32'(out_data), 32'(6'b101101));
        mux_in    = 6'b010011;
        out_ready = 1'b1;
        start     = 1'b1;
        tick("b2b");
        out_ready = 1'b0;
        start     = 1'b0;
        chk("b2b.sel0", 32'(sel), 32'd0);
        chk("b2b.busy", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 30) begin tick("b2b"); lat++; end
        chk("b2b.latency", 32'(lat), 32'd7);
        chk("b2b.word", 32'(out_data), 32'(6'b010011));
`ifdef MUX_SCAN_PARITY_EN
        chk("b2b.parity", 32'(out_parity), 32'd1);
`endif
        out_ready = 1'b1;
        tick("b2b.accept");
        out_ready = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 2) == 0);
            out_ready = $urandom_range(0, 1);
            mux_in    = N'($urandom);
            rst       = ($urandom_range(0, 59) == 0);
            tick("rand");
        end
        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        tick("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
